// File: rtl/register_level0_arbiter.sv
// -----------------------------------------------------------------------------
// register_level0_arbiter
//
// Purpose:
//   Round-robin arbiter that shares a single-port register_level0 bank
//   (one access per cycle, registered data_out one cycle after the access)
//   between N_REQ requesters. The winner of the current cycle drives the bank
//   directly; the bank's data_out is routed back to that requester on the
//   following cycle together with a one-hot response strobe.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active-high
//   req_valid     in   [N_REQ]             per-requester access request
//   req_ready     out  [N_REQ]             one-hot grant (accept = valid & ready)
//   req_wen       in   [N_REQ]             1 = write, 0 = read
//   req_addr      in   [N_REQ*ADDR_WIDTH]  requester i uses slice i
//   req_wdata     in   [N_REQ*DATA_WIDTH]  requester i uses slice i
//   rsp_valid     out  [N_REQ]             one-hot response strobe
//   rsp_rdata     out  [DATA_WIDTH]        response data, 0 when no response
//   rsp_err       out                      address error on this response
//   mem_cen_n     out                      bank enable, active-low
//   mem_wen       out                      bank write enable
//   mem_addr      out  [ADDR_WIDTH]        bank address
//   mem_data_in   out  [DATA_WIDTH]        bank write data
//   mem_data_out  in   [DATA_WIDTH]        bank registered read data
//
// Build option:
//   RL0_ARB_ADDR_CHECK_EN  when defined, a request with addr >= DEPTH is still
//                          granted but does not touch the bank, and its
//                          response carries rsp_err=1 with rsp_rdata=0.
//                          When undefined, addresses pass through unchecked
//                          and rsp_err is tied low.
// -----------------------------------------------------------------------------
module register_level0_arbiter #(
   parameter int DATA_WIDTH = 48,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 10,
   parameter int N_REQ      = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req_valid,
   output logic [N_REQ-1:0]              req_ready,
   input  logic [N_REQ-1:0]              req_wen,
   input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata,
   output logic [N_REQ-1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_err,
   output logic                          mem_cen_n,
   output logic                          mem_wen,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_data_in,
   input  logic [DATA_WIDTH-1:0]         mem_data_out
);

   localparam int                PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [PTR_W-1:0]  LAST  = PTR_W'(N_REQ - 1);
   localparam logic [PTR_W:0]    N_CMP = (PTR_W + 1)'(N_REQ);

   // Elaboration-time sanity check of the configuration.
   if (N_REQ < 2 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_cfg
      $error("register_level0_arbiter: need N_REQ >= 2 and DEPTH <= 2**ADDR_WIDTH");
   end

   logic [PTR_W-1:0]  r_rr_ptr;
   logic [N_REQ-1:0]  r_rsp_id;

   logic [N_REQ-1:0]  w_rot;
   logic              w_found;
   logic [PTR_W-1:0]  w_offset;
   logic [PTR_W:0]    w_sum;
   logic [PTR_W-1:0]  w_win_idx;
   logic [N_REQ-1:0]  w_grant;
   logic [N_REQ-1:0]  w_access;

   // ---------------------------------------------------------------------------
   // Grant: rotate the request vector so the highest-priority requester sits at
   // bit 0, pick the lowest set bit, then rotate the index back.
   // ---------------------------------------------------------------------------
   assign w_rot = N_REQ'({req_valid, req_valid} >> r_rr_ptr);

   // NOTE: every signal written in an always_comb gets a default before any
   // conditional assignment, otherwise the tool infers a latch.
   always_comb begin
      w_found  = 1'b0;
      w_offset = '0;
      // Descending scan: the lowest set bit is the last one written.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_found  = 1'b1;
            w_offset = PTR_W'(i);
         end
      end
   end

   assign w_sum     = {1'b0, r_rr_ptr} + {1'b0, w_offset};
   assign w_win_idx = (w_sum >= N_CMP) ? PTR_W'(w_sum - N_CMP) : PTR_W'(w_sum);

   // Nothing is granted while reset is asserted, so the bank stays idle.
   assign w_grant   = (w_found && !rst) ? (N_REQ'(1) << w_win_idx) : '0;
   assign req_ready = w_grant;

   // ---------------------------------------------------------------------------
   // Optional address check: an out-of-range winner completes its handshake
   // but is masked off the bank enable.
   // ---------------------------------------------------------------------------
`ifdef RL0_ARB_ADDR_CHECK_EN
   localparam logic [ADDR_WIDTH:0] DEPTH_CMP = (ADDR_WIDTH + 1)'(DEPTH);

   logic [N_REQ-1:0] w_addr_err;
   logic             r_rsp_err;

   for (genvar g = 0; g < N_REQ; g++) begin : g_addr_chk
      assign w_addr_err[g] = ({1'b0, req_addr[g*ADDR_WIDTH +: ADDR_WIDTH]} >= DEPTH_CMP);
   end

   assign w_access = w_grant & ~w_addr_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_err <= 1'b0;
      end else begin
         r_rsp_err <= |(w_grant & w_addr_err);
      end
   end

   assign rsp_err = r_rsp_err;
`else
   assign w_access = w_grant;
   assign rsp_err  = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Bank drive: mux the winner's command; all zero when nobody is granted.
   // ---------------------------------------------------------------------------
   assign mem_cen_n = ~|w_access;

   always_comb begin
      mem_wen     = 1'b0;
      mem_addr    = '0;
      mem_data_in = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_grant[i]) begin
            mem_wen     = req_wen[i];
            mem_addr    = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            mem_data_in = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Pointer and response tracking. The response slot is simply the grant
   // delayed by one cycle, which lines up with the bank's registered data_out.
   // ---------------------------------------------------------------------------
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr <= '0;
         r_rsp_id <= '0;
      end else begin
         r_rsp_id <= w_grant;
         if (|w_grant) begin
            r_rr_ptr <= (w_win_idx == LAST) ? '0 : w_win_idx + 1'b1;
         end
      end
   end

   assign rsp_valid = r_rsp_id;
   assign rsp_rdata = (|r_rsp_id && !rsp_err) ? mem_data_out : '0;

endmodule
